// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with a bounded hold time.
// An owner that holds past MAX_HOLD cycles is preempted unless it asserts its lock.
module bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic       preempt
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state_reg;
  logic [3:0] grant_reg;
  logic       grant_valid_reg;
  logic [1:0] grant_id_reg;
  logic       preempt_reg;
  logic [3:0] hold_cnt_reg;
  logic [1:0] last_id_reg;

  logic [3:0] cand_mask;
  logic [3:0] rr_hit;
  logic [1:0] rr_idx [4];
  logic       win_valid;
  logic [1:0] win_id;
  logic       owner_req;
  logic       owner_lock;
  logic       hold_sat;
  logic       take_new;
  logic       do_preempt;
  logic       go_idle;

  // The current owner is masked out, so the same search serves both release and preemption.
  assign cand_mask = req & ~grant_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rr
      assign rr_idx[gi] = last_id_reg + 2'(gi + 1);
      assign rr_hit[gi] = cand_mask[rr_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_valid = 1'b1;
    win_id    = rr_idx[0];
    casez (rr_hit)
      4'b???1: win_id = rr_idx[0];
      4'b??10: win_id = rr_idx[1];
      4'b?100: win_id = rr_idx[2];
      4'b1000: win_id = rr_idx[3];
      default: win_valid = 1'b0;
    endcase
  end

  assign owner_req  = req[grant_id_reg];
  assign owner_lock = lock[grant_id_reg];
  assign hold_sat   = (hold_cnt_reg == HOLD_MAX);

  always_comb begin
    take_new   = 1'b0;
    do_preempt = 1'b0;
    go_idle    = 1'b0;
    case (state_reg)
      IDLE: begin
        take_new = win_valid;
      end
      OWNED: begin
        if (!owner_req) begin
          take_new = win_valid;
          go_idle  = !win_valid;
        end else if (hold_sat && !owner_lock && win_valid) begin
          take_new   = 1'b1;
          do_preempt = 1'b1;
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg       <= IDLE;
      grant_reg       <= 4'b0000;
      grant_valid_reg <= 1'b0;
      grant_id_reg    <= 2'd0;
      preempt_reg     <= 1'b0;
      hold_cnt_reg    <= 4'd0;
      last_id_reg     <= 2'd3;
    end else begin
      preempt_reg <= do_preempt;
      if (take_new) begin
        state_reg       <= OWNED;
        grant_reg       <= 4'b0001 << win_id;
        grant_valid_reg <= 1'b1;
        grant_id_reg    <= win_id;
        last_id_reg     <= win_id;
        hold_cnt_reg    <= 4'd0;
      end else if (go_idle) begin
        // grant_id deliberately keeps the last owner while idle
        state_reg       <= IDLE;
        grant_reg       <= 4'b0000;
        grant_valid_reg <= 1'b0;
        hold_cnt_reg    <= 4'd0;
      end else if (state_reg == OWNED && !hold_sat) begin
        hold_cnt_reg <= hold_cnt_reg + 4'd1;
      end
    end
  end

  assign grant       = grant_reg;
  assign grant_valid = grant_valid_reg;
  assign grant_id    = grant_id_reg;
  assign preempt     = preempt_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset priority, rotation, preemption, lock, idle and async clear.
module tb_bus_arbiter;

  logic       clk;
  logic       clr;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       preempt;

  int n_checks = 0;
  int n_errors = 0;
  logic prev_preempt = 1'b0;
  logic mon_en = 1'b0;

  bus_arbiter #(.MAX_HOLD(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .lock       (lock),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge with the current inputs; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    $display("txn t=%0t req=%b lock=%b grant=%b valid=%b id=%0d preempt=%b",
             $time, req, lock, grant, grant_valid, grant_id, preempt);
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic pe);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_id"}, 32'(grant_id), 32'(id));
    chk({tag, "_preempt"}, 32'(preempt), 32'(pe));
  endtask

  // Per-cycle invariants
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_onehot", 32'((grant & (grant - 4'd1)) == 4'd0), 32'd1);
      chk("inv_valid", 32'(grant_valid), 32'(|grant));
      chk("inv_preempt2", 32'(preempt & prev_preempt), 32'd0);
    end
    prev_preempt = preempt;
  end

  initial begin
    clr  = 1'b1;
    req  = 4'b0000;
    lock = 4'b0000;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_preempt", 32'(preempt), 32'd0);

    // Reset priority: requester 0 wins first
    clr = 1'b0;
    req = 4'b1111;
    step();
    expect_grant("rp0", 4'b0001, 2'd0, 1'b0);
    chk("rp0_valid", 32'(grant_valid), 32'd1);
    req = 4'b1110;
    step();
    expect_grant("rp1", 4'b0010, 2'd1, 1'b0);

    // Rotation with wrap 3 -> 1
    req = 4'b1010;
    step();
    expect_grant("rot_hold", 4'b0010, 2'd1, 1'b0);
    req = 4'b1000;
    step();
    expect_grant("rot_to3", 4'b1000, 2'd3, 1'b0);
    req = 4'b0010;
    step();
    expect_grant("rot_wrap1", 4'b0010, 2'd1, 1'b0);

    // Simultaneous requests resolved from last_id=1: search 2,3,0
    req = 4'b1101;
    step();
    expect_grant("rr_sim2", 4'b0100, 2'd2, 1'b0);
    req = 4'b1001;
    step();
    expect_grant("rr_sim3", 4'b1000, 2'd3, 1'b0);

    // Release to idle keeps grant_id
    req = 4'b0000;
    step();
    expect_grant("idle", 4'b0000, 2'd3, 1'b0);
    chk("idle_valid", 32'(grant_valid), 32'd0);

    // Preemption after 9 owned cycles
    req = 4'b0101;
    for (int i = 0; i < 9; i++) begin
      step();
      expect_grant($sformatf("pre_hold%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    step();
    expect_grant("pre_hand", 4'b0100, 2'd2, 1'b1);
    step();
    expect_grant("pre_after", 4'b0100, 2'd2, 1'b0);

    // Lock: no handoff while locked, handoff on the edge after unlock
    req = 4'b0000;
    step();
    expect_grant("lk_idle", 4'b0000, 2'd2, 1'b0);
    req  = 4'b0101;
    lock = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      expect_grant($sformatf("lk_hold%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    lock = 4'b0000;
    step();
    expect_grant("lk_hand", 4'b0100, 2'd2, 1'b1);
    step();
    expect_grant("lk_after", 4'b0100, 2'd2, 1'b0);

    // Saturated owner alone keeps the bus
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      step();
      expect_grant($sformatf("sat%0d", i), 4'b0100, 2'd2, 1'b0);
    end

    // Mid-ownership async clear drops grant before any edge
    clr = 1'b1;
    #1;
    chk("clr_grant", 32'(grant), 32'd0);
    chk("clr_valid", 32'(grant_valid), 32'd0);
    chk("clr_id", 32'(grant_id), 32'd0);
    step();
    expect_grant("clr_held", 4'b0000, 2'd0, 1'b0);
    clr = 1'b0;
    step();
    expect_grant("clr_restart", 4'b0100, 2'd2, 1'b0);
    chk("clr_restart_valid", 32'(grant_valid), 32'd1);

    req = 4'b0000;
    step();
    expect_grant("end_idle", 4'b0000, 2'd2, 1'b0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8 (range 2..15): maximum cycles an unlocked owner keeps the bus while others wait.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-003 The block SHALL have port clr, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4: per-requester bus request, level-sensitive.
REQ-005 The block SHALL have port lock, input, 4: per-requester no-preempt hold; only lock[owner] is significant.
REQ-006 The block SHALL have port grant, output, 4: registered one-hot bus grant, all-zero when idle.
REQ-007 The block SHALL have port grant_valid, output, 1: registered; high iff grant is nonzero.
REQ-008 The block SHALL have port grant_id, output, 2: registered index of the owner; holds its last value when idle.
REQ-009 The block SHALL have port preempt, output, 1: registered one-cycle pulse on a forced handoff.

Function
REQ-010 The block SHALL implement two states: IDLE (no owner) and OWNED (one owner).
REQ-011 IDLE: if req != 0 at a clock edge, the block SHALL enter OWNED with the round-robin winner granted on that edge (one-cycle request-to-grant latency).
REQ-012 Round-robin SHALL search indices last_id+1, +2, +3, +4 (mod 4) and pick the first with req set; last_id is updated to each new owner.
REQ-013 OWNED: while req[owner]=1 and no preemption applies, grant, grant_id and state SHALL remain unchanged.
REQ-014 Release: if req[owner]=0 at an edge and another req is set, the block SHALL grant the round-robin winner on that same edge (no idle bubble); if none is set, it SHALL go to IDLE with grant=0.
REQ-015 Hold counter: it SHALL be 4 bits, cleared to 0 on every new grant, incremented each OWNED cycle, and saturate at MAX_HOLD.
REQ-016 Preemption SHALL occur at an edge where hold_cnt==MAX_HOLD, lock[owner]=0, req[owner]=1, and some other req is set: grant moves to the round-robin winner excluding owner, and preempt=1 for exactly one cycle.
REQ-017 With lock[owner]=1 the owner SHALL never be preempted regardless of hold_cnt; if lock drops while saturated and others wait, preemption SHALL occur on the next edge.
REQ-018 A saturated owner with no other requester SHALL keep the grant indefinitely, with no preempt pulse.
REQ-019 grant SHALL never have more than one bit set, and SHALL never be given to a requester whose req was 0 at the deciding edge.
REQ-020 Requests arriving simultaneously SHALL be resolved solely by the round-robin order of REQ-012.
REQ-021 preempt SHALL be 0 on all edges other than those defined in REQ-016.

Reset
REQ-022 While clr=1 the block SHALL asynchronously hold: state=IDLE, grant=4'b0000, grant_valid=0, grant_id=2'd0, preempt=0, hold_cnt=0, last_id=2'd3, so that requester 0 wins first after reset.
REQ-023 clr asserted mid-ownership SHALL drop grant immediately, without waiting for a clock edge; after clr deasserts, arbitration SHALL restart from IDLE per REQ-011.

Verification
REQ-024 The bench SHALL cover reset priority: release clr, req=4'b1111 -> next edge grant=0001, grant_id=0; drop req[0] -> next edge grant=0010.
REQ-025 The bench SHALL cover rotation: with MAX_HOLD=8, req=4'b1010 held after owner 1 releases -> grant=1000; owner 3 releases -> grant=0010; last_id wraps 3->1.
REQ-026 The bench SHALL cover preemption: owner 0 holds req with lock=0 and req[2]=1 -> grant=0001 for 9 cycles (hold_cnt 0..8), then grant=0100 with preempt=1 for one cycle.
REQ-027 The bench SHALL cover lock: as REQ-026 with lock[0]=1 for 20 cycles -> no handoff and preempt=0 throughout; lock[0]=0 -> handoff to 2 with preempt=1 on the next edge.
REQ-028 The bench SHALL cover release to idle and mid-op reset: sole owner drops req -> next edge grant=0, grant_valid=0, grant_id retained; clr pulse mid-grant -> grant=0 before the next edge, and req=4'b0100 afterwards -> grant=0100 one edge later.
REQ-029 The bench SHALL check invariants every cycle: grant is one-hot or zero; grant_valid == |grant; preempt is never high for two consecutive cycles.
